mem_issue_queue: RTL

In-order issue queue for memory instructions, placed directly upstream of the `lsu`. It accepts load/store micro-ops from dispatch and holds each one until its source operands arrive, either at dispatch or by snooping the common data bus (CDB). When the LSU is idle, it issues the oldest ready entry, presenting `pc`/`inst`/`rs1`/`rs2` with a one-cycle `lsu_request_o` pulse. Memory ops always leave in program order; a non-ready head blocks all younger entries.

---
 rtl/mem_iq_pkg.sv | 27 ++
 rtl/mem_iq_opnd_capture.sv | 22 ++
 rtl/mem_issue_queue.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_iq_pkg.sv
// Shared types and constants for the memory issue queue.
package mem_iq_pkg;

    // Major opcodes of the memory instructions the queue carries.
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Width of the ROB tag stored in every operand slot. Module TAG_W
    // parameters default to this value and are size-cast onto it.
    localparam int MEM_IQ_TAG_W = 5;

    // One source operand: ready flag, producer tag, captured value.
    typedef struct packed {
        logic                    rdy;
        logic [MEM_IQ_TAG_W-1:0] tag;
        logic [31:0]             value;
    } mem_iq_opnd_t;

    // One queued memory op.
    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  inst;
        mem_iq_opnd_t rs1;
        mem_iq_opnd_t rs2;
    } mem_iq_entry_t;

endpackage

// File: rtl/mem_iq_opnd_capture.sv
// Tag compare and capture for a single operand slot: a waiting operand whose
// tag matches a valid CDB broadcast takes the broadcast value and becomes ready.
module mem_iq_opnd_capture
    import mem_iq_pkg::*;
(
    input  mem_iq_opnd_t            opnd,
    input  logic                    cdb_valid,
    input  logic [MEM_IQ_TAG_W-1:0] cdb_tag,
    input  logic [31:0]             cdb_value,
    output mem_iq_opnd_t            opnd_next
);

    // Pass the operand through, replacing it on a matching broadcast.
    always_comb begin
        opnd_next = opnd;
        if (cdb_valid && !opnd.rdy && (opnd.tag == cdb_tag)) begin
            opnd_next.rdy   = 1'b1;
            opnd_next.value = cdb_value;
        end
    end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order issue queue for load/store micro-ops feeding the LSU.
// Ops wait for their operands (at dispatch or from the CDB) and leave strictly
// in program order, one lsu_request_o pulse per op with an idle cycle between.
// Optional feature macro: MEMQ_CDB_BYPASS_EN lets the head issue in the same
// cycle its last missing operand appears on the CDB.
//
// Dispatch handshake: an op is accepted at a rising edge where disp_valid_i and
// disp_ready_o are both high; disp_ready_o depends only on the registered
// count, never on disp_valid_i or on a same-cycle issue.
module mem_issue_queue
    import mem_iq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = MEM_IQ_TAG_W
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       disp_valid_i,
    output logic                       disp_ready_o,
    input  logic [31:0]                disp_pc_i,
    input  logic [31:0]                disp_inst_i,
    input  logic                       disp_rs1_rdy_i,
    input  logic                       disp_rs2_rdy_i,
    input  logic [TAG_W-1:0]           disp_rs1_tag_i,
    input  logic [TAG_W-1:0]           disp_rs2_tag_i,
    input  logic [31:0]                disp_rs1_value_i,
    input  logic [31:0]                disp_rs2_value_i,
    input  logic                       cdb_valid_i,
    input  logic [TAG_W-1:0]           cdb_tag_i,
    input  logic [31:0]                cdb_value_i,
    input  logic                       lsu_busy_i,
    output logic                       lsu_request_o,
    output logic [31:0]                pc_o,
    output logic [31:0]                inst_o,
    output logic [31:0]                rs1_value_o,
    output logic [31:0]                rs2_value_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    mem_iq_entry_t           q        [DEPTH];
    mem_iq_opnd_t            rs1_next [DEPTH];
    mem_iq_opnd_t            rs2_next [DEPTH];
    mem_iq_opnd_t            enq_rs1_raw, enq_rs2_raw;
    mem_iq_opnd_t            enq_rs1, enq_rs2;
    logic [MEM_IQ_TAG_W-1:0] cdb_tag;
    logic [PTR_W-1:0]        head, tail;
    logic [CNT_W-1:0]        count;
    logic                    lsu_request;
    logic                    enq, issue;
    logic                    head_rs1_rdy, head_rs2_rdy;
    logic [31:0]             head_rs1_value, head_rs2_value;

    assign cdb_tag       = MEM_IQ_TAG_W'(cdb_tag_i);
    assign count_o       = count;
    assign disp_ready_o  = (count < CNT_W'(DEPTH));
    assign lsu_request_o = lsu_request;
    assign enq           = disp_valid_i && disp_ready_o;

    // Build the incoming operands; loads have no rs2, so it is born ready as 0.
    always_comb begin
        enq_rs1_raw = '{rdy: disp_rs1_rdy_i, tag: MEM_IQ_TAG_W'(disp_rs1_tag_i),
                        value: disp_rs1_value_i};
        enq_rs2_raw = '{rdy: disp_rs2_rdy_i, tag: MEM_IQ_TAG_W'(disp_rs2_tag_i),
                        value: disp_rs2_value_i};
        if (disp_inst_i[6:0] == OPC_LOAD) begin
            enq_rs2_raw = '{rdy: 1'b1, tag: '0, value: 32'h0};
        end
    end

    // The enqueue path snoops too, so a broadcast in the dispatch cycle is not lost.
    mem_iq_opnd_capture u_enq_rs1 (
        .opnd(enq_rs1_raw), .cdb_valid(cdb_valid_i), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value_i), .opnd_next(enq_rs1)
    );
    mem_iq_opnd_capture u_enq_rs2 (
        .opnd(enq_rs2_raw), .cdb_valid(cdb_valid_i), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value_i), .opnd_next(enq_rs2)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        mem_iq_opnd_capture u_rs1 (
            .opnd(q[i].rs1), .cdb_valid(cdb_valid_i), .cdb_tag(cdb_tag),
            .cdb_value(cdb_value_i), .opnd_next(rs1_next[i])
        );
        mem_iq_opnd_capture u_rs2 (
            .opnd(q[i].rs2), .cdb_valid(cdb_valid_i), .cdb_tag(cdb_tag),
            .cdb_value(cdb_value_i), .opnd_next(rs2_next[i])
        );
    end

`ifdef MEMQ_CDB_BYPASS_EN
    // Head readiness includes this cycle's broadcast.
    always_comb begin
        head_rs1_rdy   = rs1_next[head].rdy;
        head_rs2_rdy   = rs2_next[head].rdy;
        head_rs1_value = rs1_next[head].value;
        head_rs2_value = rs2_next[head].value;
    end
`else
    // Head readiness comes from the registered entry only.
    always_comb begin
        head_rs1_rdy   = q[head].rs1.rdy;
        head_rs2_rdy   = q[head].rs2.rdy;
        head_rs1_value = q[head].rs1.value;
        head_rs2_value = q[head].rs2.value;
    end
`endif

    // Issue only from an idle LSU and never on two consecutive cycles.
    always_comb begin
        issue = (count != '0) && head_rs1_rdy && head_rs2_rdy &&
                !lsu_busy_i && !lsu_request && !flush_i;
    end

    // Entry storage: every slot snoops each cycle; the tail slot takes the new op.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            q[i].rs1 <= rs1_next[i];
            q[i].rs2 <= rs2_next[i];
        end
        if (reset_i && !flush_i && enq) begin
            q[tail] <= '{pc: disp_pc_i, inst: disp_inst_i, rs1: enq_rs1, rs2: enq_rs2};
        end
    end

    // Pointers, occupancy, issue pulse and the held output registers.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            lsu_request <= 1'b0;
            pc_o        <= '0;
            inst_o      <= '0;
            rs1_value_o <= '0;
            rs2_value_o <= '0;
        end else if (flush_i) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            lsu_request <= 1'b0;
        end else begin
            lsu_request <= issue;
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (issue) begin
                head        <= head + PTR_W'(1);
                pc_o        <= q[head].pc;
                inst_o      <= q[head].inst;
                rs1_value_o <= head_rs1_value;
                rs2_value_o <= head_rs2_value;
            end
            case ({enq, issue})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
